// File: rtl/capture_arbiter.sv
// Round-robin arbiter sharing one capture FIFO write port among the UART, SPI and I2C decoders.
// Each source lands in a one-byte holding slot; a rotating scheduler drains one slot per cycle.
module capture_arbiter #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        en_mask,
    input  logic [2:0]        src_valid,
    input  logic [7:0]        src_data0,
    input  logic [7:0]        src_data1,
    input  logic [7:0]        src_data2,
    output logic [2:0]        src_ready,
    output logic              fifo_write_en,
    output logic [1:0]        fifo_proto_id,
    output logic [7:0]        fifo_data,
    input  logic              fifo_overflow,
    input  logic              clear_drops,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    logic [2:0] slot_full;
    logic [2:0] slot_full_nxt;
    logic [7:0] slot_data [3];
    logic [7:0] src_data  [3];
    logic [1:0] last;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] grant;
    logic       grant_vld;
    logic [2:0] accept;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

    assign src_data[0] = src_data0;
    assign src_data[1] = src_data1;
    assign src_data[2] = src_data2;

    // Ready depends only on registered slot state and the enable mask.
    assign src_ready = en_mask & ~slot_full;
    assign accept    = src_valid & src_ready;
    assign busy      = (|slot_full) | fifo_write_en;

    // Search order is last+1, last+2, then last itself (mod 3).
    always_comb begin
        cand1     = next_idx(last);
        cand2     = next_idx(cand1);
        grant_vld = |slot_full;
        grant     = last;
        if (slot_full[cand1]) begin
            grant = cand1;
        end else if (slot_full[cand2]) begin
            grant = cand2;
        end
    end

    // Accept only targets empty slots and drain only full ones, so the two never collide.
    always_comb begin
        slot_full_nxt = slot_full;
        if (grant_vld) begin
            slot_full_nxt[grant] = 1'b0;
        end
        slot_full_nxt = slot_full_nxt | accept;
    end

    // Stage p0: holding slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= 3'b000;
        end else begin
            slot_full <= slot_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
                slot_data[i] <= src_data[i];
            end
        end
    end

    // Stage p1: FIFO write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_write_en <= 1'b0;
            fifo_proto_id <= 2'd0;
            fifo_data     <= 8'h00;
            last          <= 2'd2;
        end else begin
            fifo_write_en <= grant_vld;
            if (grant_vld) begin
                fifo_proto_id <= grant;
                fifo_data     <= slot_data[grant];
                last          <= grant;
            end
        end
    end

    // Clear takes priority over a coincident overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (clear_drops) begin
            drop_count <= '0;
        end else if (fifo_overflow) begin
            drop_count <= sat_inc(drop_count);
        end
    end

endmodule
